// File: rtl/rd_win_pkg.sv
// Shared types and constants for the read-window controller.
//   NUM_REQ        : number of requesters arbitrated (fixed at 2)
//   rd_win_state_e : controller FSM state encoding
package rd_win_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    COMPLETE = 2'd2
  } rd_win_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  : per-requester request bits
//   last : index of the requester granted most recently
//   win  : one-hot winner, zero when no request is pending
// The requester that was not granted last gets priority.
module rr_arb2
  import rd_win_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    if (last) begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end else begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end
  end

endmodule

// File: rtl/rd_win_ctrl.sv
// Read-window controller: arbitrates two requesters, opens a registered rd
// window carrying the winner's data word, and closes it on rd_ack or after
// TIMEOUT cycles without one.
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   enable         : permits new grants (an open window always finishes)
//   req            : per-requester request, held until done/timeout
//   data0, data1   : per-requester data words
//   rd, data_out   : registered read window and the data latched at launch
//   rd_ack         : responder acknowledge, only honoured while rd is high
//   gnt            : one-hot owner of the current window
//   done           : one-cycle pulse to the owner after an acknowledged window
//   timeout, err   : one-cycle timeout pulse, and its sticky flag
module rd_win_ctrl
  import rd_win_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  output logic               rd,
  output logic [DATA_W-1:0]  data_out,
  input  logic               rd_ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout,
  output logic               err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  rd_win_state_e      state_q, state_d;
  logic               rd_q, rd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               to_q, to_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] win;

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    to_d    = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (|req)) begin
          state_d = WAIT_ACK;
          rd_d    = 1'b1;
          gnt_d   = win;
          data_d  = win[1] ? data1 : data0;
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        // Ack takes precedence over an expiring counter on the same cycle.
        if (rd_ack) begin
          state_d = COMPLETE;
          rd_d    = 1'b0;
          done_d  = gnt_q;
          gnt_d   = '0;
          last_d  = gnt_q[1];
        end else if (cnt_q == CNT_LAST) begin
          // A timed-out owner still counts as last granted.
          state_d = IDLE;
          rd_d    = 1'b0;
          to_d    = 1'b1;
          err_d   = 1'b1;
          gnt_d   = '0;
          last_d  = gnt_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      data_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      to_q    <= to_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign rd       = rd_q;
  assign data_out = data_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign timeout  = to_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rd_win_ctrl.sv
// Directed bench for rd_win_ctrl (DATA_W=8, TIMEOUT=16). Inputs change 1ns
// after each rising edge; outputs are checked at that same point.
module tb_rd_win_ctrl;

  logic       clock, reset, enable, rd, rd_ack, timeout, err;
  logic [1:0] req, gnt, done;
  logic [7:0] data0, data1, data_out;

  int checks = 0;
  int fails  = 0;
  int n_rd;

  rd_win_ctrl #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .rd       (rd),
    .data_out (data_out),
    .rd_ack   (rd_ack),
    .gnt      (gnt),
    .done     (done),
    .timeout  (timeout),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Called in the first rd cycle. Holds rd_ack high during window cycle
  // ack_at (0 = never), optionally toggles data0 every cycle, and returns
  // the number of cycles rd stayed high. Exits in the cycle after rd falls.
  task automatic window(input int ack_at, input logic [1:0] egnt,
                        input logic [7:0] edata, input bit toggle,
                        output int n);
    n = 0;
    while (rd === 1'b1 && n < 40) begin
      n++;
      chk("win_gnt", gnt, egnt);
      chk("win_data", data_out, edata);
      chk("win_done", done, 0);
      if (toggle) data0 = (data0 == 8'hA5) ? 8'h5A : 8'hA5;
      rd_ack = (n == ack_at);
      tick();
    end
    rd_ack = 1'b0;
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    reset = 1'b0; enable = 1'b0; req = 2'b00; rd_ack = 1'b0;
    data0 = 8'hA5; data1 = 8'h3C;
    tick(); tick();
    chk("rst_rd", rd, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout, 0);
    chk("rst_err", err, 0);
    chk("rst_data", data_out, 0);
    reset = 1'b1;
    tick();

    // Single acknowledged window on requester 0.
    enable = 1'b1; req = 2'b01;
    tick();
    chk("t1_rd_lat", rd, 1);
    window(3, 2'b01, 8'hA5, 1'b0, n_rd);
    chk("t1_rd_cycles", n_rd, 3);
    chk("t1_done", done, 2'b01);
    chk("t1_gnt_clr", gnt, 0);
    chk("t1_to", timeout, 0);
    req = 2'b00;
    tick();
    chk("t1_done_once", done, 0);
    chk("t1_err", err, 0);

    // rd_ack while idle is ignored.
    rd_ack = 1'b1;
    tick(); tick();
    chk("t2_idle_rd", rd, 0);
    chk("t2_idle_done", done, 0);
    rd_ack = 1'b0;

    // enable low blocks new grants.
    enable = 1'b0; req = 2'b10;
    tick(); tick(); tick();
    chk("t3_blk_rd", rd, 0);
    chk("t3_blk_gnt", gnt, 0);

    // Timeout on requester 1; enable drops mid-window without effect.
    enable = 1'b1;
    tick();
    chk("t4_rd", rd, 1);
    enable = 1'b0;
    window(0, 2'b10, 8'h3C, 1'b0, n_rd);
    chk("t4_rd_cycles", n_rd, 16);
    chk("t4_to", timeout, 1);
    chk("t4_err", err, 1);
    chk("t4_done", done, 0);
    chk("t4_gnt", gnt, 0);
    req = 2'b00; enable = 1'b1;
    tick();
    chk("t4_to_once", timeout, 0);
    chk("t4_err_sticky", err, 1);

    // Both requesting: grants alternate, starting with 0 since 1 timed out.
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        chk("t5_gap_rd", rd, 0);
      end
      tick();
      chk("t5_rd", rd, 1);
      window(2, rr_exp[i], (rr_exp[i] == 2'b01) ? 8'hA5 : 8'h3C, 1'b0, n_rd);
      chk("t5_rd_cycles", n_rd, 2);
      chk("t5_done", done, rr_exp[i]);
    end
    req = 2'b00;
    tick();

    // data0 toggling during the window leaves data_out alone.
    req = 2'b01; data0 = 8'hA5;
    tick();
    window(4, 2'b01, 8'hA5, 1'b1, n_rd);
    chk("t6_rd_cycles", n_rd, 4);
    chk("t6_data_hold", data_out, 8'hA5);
    chk("t6_done", done, 2'b01);
    req = 2'b00; data0 = 8'hA5;
    tick();

    // Ack on the last allowed cycle wins over timeout.
    req = 2'b10;
    tick();
    window(16, 2'b10, 8'h3C, 1'b0, n_rd);
    chk("t7_rd_cycles", n_rd, 16);
    chk("t7_done", done, 2'b10);
    chk("t7_to", timeout, 0);
    chk("t7_err_sticky", err, 1);
    req = 2'b00;
    tick();

    // Asynchronous reset two cycles into a window.
    req = 2'b10;
    tick();
    chk("t8_rd", rd, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("t8_rst_rd", rd, 0);
    chk("t8_rst_gnt", gnt, 0);
    chk("t8_rst_done", done, 0);
    chk("t8_rst_to", timeout, 0);
    chk("t8_rst_err", err, 0);
    tick();
    reset = 1'b1;
    req = 2'b11;
    tick();
    chk("t8_post_gnt", gnt, 2'b01);
    chk("t8_post_rd", rd, 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("t8_post_done", done, 2'b01);
    chk("t8_post_to", timeout, 0);
    req = 2'b00;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
